// File: rtl/fp_arb_pkg.sv
// Shared constants and types for the floating-point adder arbiter:
// adder opcodes, the sequencing state enum and the quiet-NaN pattern.
package fp_arb_pkg;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-way round-robin arbiter: scans the request vector starting at ptr_i
// and returns a one-hot grant plus the granted index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr_i never exceeds NREQ-1, so one wrap is enough
            k = int'(ptr_i) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (en_i && !any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one float_point_add unit between NREQ requesters with round-robin
// arbitration, one operation in flight, illegal-opcode rejection and timeout.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | arbitrate, accept one request, capture operands
//   ST_ISSUE | operands and opcode presented to the adder, clear timer
//   ST_WAIT  | hold adder inputs, wait for done or timer expiry
//   ST_RESP  | one-cycle response strobe to the granted requester
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      iReqValid,
    input  logic [NREQ*32-1:0]   iReqA,
    input  logic [NREQ*32-1:0]   iReqB,
    input  logic [NREQ*2-1:0]    iReqOp,
    output logic [NREQ-1:0]      oReqReady,
    output logic [NREQ-1:0]      oRspValid,
    output logic [31:0]          oRspF,
    output logic                 oRspErr,
    output logic [31:0]          oA,
    output logic [31:0]          oB,
    output logic [1:0]           oOp,
    input  logic [31:0]          iF,
    input  logic                 iDone
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   g_q, g_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rsp_q, rsp_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            arb_en;
    logic [1:0]      sel_op;

    // Grants are suppressed while reset is held so no request looks accepted.
    assign arb_en = (state_q == ST_IDLE) && resetn;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req_i (iReqValid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign sel_op = iReqOp[int'(gnt_idx)*2 +: 2];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    g_d   = gnt_idx;
                    ptr_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                    if (op_legal(sel_op)) begin
                        a_d     = iReqA[int'(gnt_idx)*32 +: 32];
                        b_d     = iReqB[int'(gnt_idx)*32 +: 32];
                        op_d    = sel_op;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        rsp_d   = QNAN;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over expiry in the same cycle.
                if (iDone) begin
                    rsp_d   = iF;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT-2)) begin
                    rsp_d   = QNAN;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_IDLE;
            cnt_q   <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        oRspValid = '0;
        if (state_q == ST_RESP) begin
            oRspValid[g_q] = 1'b1;
        end
    end

    assign oReqReady = gnt;
    assign oRspF     = rsp_q;
    assign oRspErr   = (state_q == ST_RESP) && err_q;
    assign oA        = a_q;
    assign oB        = b_q;
    assign oOp       = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? op_q : OP_IDLE;

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Shares a single `float_point_add` unit between `NREQ` independent requesters. Arbitration is round-robin. Exactly one operation is in flight at a time. The block drives the adder's operand and opcode inputs, waits for its `oDone`, and returns the result to the granted requester. It also rejects illegal opcodes and recovers from an adder that never completes. It sits between the requesting engines and the adder, and is the only block allowed to drive the adder's `iA`, `iB` and `iOp` inputs.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2 to 8.
- `TIMEOUT`, default 64: maximum number of cycles in WAIT before the operation is aborted.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `iReqValid`  in  NREQ  per-requester request valid.
- `iReqA`  in  NREQ*32  per-requester operand A, IEEE-754 single precision; requester k uses bits [32k+31:32k].
- `iReqB`  in  NREQ*32  per-requester operand B, same packing as `iReqA`.
- `iReqOp`  in  NREQ*2  per-requester opcode; requester k uses bits [2k+1:2k].
- `oReqReady`  out  NREQ  one-hot grant; a request is accepted in the cycle where valid and ready are both 1.
- `oRspValid`  out  NREQ  one-hot, one-cycle response strobe.
- `oRspF`  out  32  result, shared by all requesters and valid while any `oRspValid` bit is 1.
- `oRspErr`  out  1  error flag qualified by `oRspValid`: set for an illegal opcode or a timeout.
- `oA`  out  32  operand A to the adder (`iA`).
- `oB`  out  32  operand B to the adder (`iB`).
- `oOp`  out  2  opcode to the adder (`iOp`).
- `iF`  in  32  result from the adder (`oF`).
- `iDone`  in  1  completion from the adder (`oDone`).

## Operation
Opcodes:
- 2'b00 means idle. The block drives it whenever no operation is in flight.
- 2'b01 means add.
- 2'b10 means subtract.
- 2'b11 is reserved. Requests with 00 or 11 are illegal.

State machine, with states IDLE, ISSUE, WAIT and RESP:
- **IDLE**
  - The round-robin arbiter examines `iReqValid`, starting at pointer `ptr`.
  - For the first valid requester g, `oReqReady[g]=1`; this is combinational within the same cycle.
  - On acceptance, A, B and opcode are captured and `ptr` becomes g+1 mod NREQ.
  - A legal opcode moves to ISSUE. An illegal opcode moves to RESP with the error flag set, and the adder is not touched.
  - If no request is valid, all ready bits are 0 and `ptr` is unchanged.
- **ISSUE**
  - `oA`, `oB` and `oOp` are driven from the captured registers.
  - Moves to WAIT next cycle, and the timeout counter is cleared.
- **WAIT**
  - `oA`, `oB` and `oOp` are held stable.
  - The counter increments every cycle.
  - On the first cycle with `iDone=1`, `iF` is captured, the error flag is cleared and the state moves to RESP.
  - If the counter reaches `TIMEOUT-1` without `iDone`, the state moves to RESP with the error flag set and `oRspF=32'h7FC00000` (quiet NaN).
- **RESP**
  - `oRspValid[g]=1` for exactly one cycle, and `oOp` is 00.
  - Moves to IDLE.
  - There is no response backpressure: requesters must sample the response in that cycle.

Rules:
- `oReqReady` is 0 in every state other than IDLE. After acceptance, a requester may change its inputs freely.
- An `iDone` that arrives outside WAIT is ignored.
- `iDone` and the timeout in the same cycle: `iDone` wins.
- At most one bit of `oReqReady` and one bit of `oRspValid` is ever set.

## Timing
- Reset values:
  - State is IDLE and `ptr=0`.
  - `oReqReady=0`, `oRspValid=0`, `oRspErr=0`.
  - `oRspF=0`, `oA=0`, `oB=0`, `oOp=2'b00`.
- Legal-op latency: accepted in cycle t, operands on the adder in t+1, adder done in cycle d ≥ t+2, response in d+1.
- Illegal-op latency: accepted in cycle t, response in t+1.
- The next acceptance can happen at the earliest in the cycle after RESP, so the minimum legal-op occupancy is 4 cycles.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Reset asserted mid-operation: all state is cleared immediately and no response is issued for the in-flight request. After `resetn` rises, the first grant goes to requester 0.

## Structure
- Package `fp_arb_pkg` holds:
  - the opcode constants OP_IDLE, OP_ADD, OP_SUB and OP_RSVD;
  - the state enum;
  - the constant QNAN = 32'h7FC00000.
- One sub-module, `rr_arbiter`: a parameterised NREQ-way round-robin arbiter. It takes the request vector, the pointer and an enable, and returns a one-hot grant plus the granted index. It is instantiated once.
- The top level contains the state machine, the capture registers, the timeout counter and the adder-side outputs.

## Test plan
- Single add: requester 0 sends A=32'h41480000, B=32'h41080000, op=01. A model adder asserts done 3 cycles after ISSUE with F=32'h41A80000. Required: `oRspValid[0]` one cycle, `oRspF=32'h41A80000`, `oRspErr=0`, and `oOp` back to 00.
- Round-robin: requesters 0-3 are all valid continuously. Required: grants go 0,1,2,3,0; each response bit goes only to its own granted requester; `oA` stays stable throughout WAIT.
- Illegal op: requester 2 sends op=11. Required: `oRspValid[2]` in the next cycle with `oRspErr=1`; `oOp` stays 00 throughout.
- Timeout: the adder never asserts done. Required: `oRspErr=1` and `oRspF=32'h7FC00000` exactly TIMEOUT cycles after ISSUE, after which the block returns to IDLE and accepts new requests.
- Done and timeout in the same cycle: required response is the adder's `iF` with `oRspErr=0`.
- Reset mid-WAIT: assert `resetn=0` during WAIT. Required: all outputs take their reset values asynchronously, no response is issued, and the next grant goes to requester 0.
